// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/half_adder.sv
// Half-adder cell: sum and carry of two single bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// Full adder built from two half-adder cells with their carries ORed together.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic partialSum;
    logic carry1;
    logic carry2;

    half_adder ha0 (
        .a (x),
        .b (y),
        .s (partialSum),
        .c (carry1)
    );

    half_adder ha1 (
        .a (partialSum),
        .b (ci),
        .s (s),
        .c (carry2)
    );

    assign co = carry1 | carry2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a registered carry, LSB first,
// one result per start with a single-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [WIDTH-1:0] sSr_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             sumBit;
    logic             carryBit;
    logic [WIDTH-1:0] sSr_d;

    full_adder fa (
        .x  (aSr_q[0]),
        .y  (bSr_q[0]),
        .ci (c_q),
        .s  (sumBit),
        .co (carryBit)
    );

    assign sSr_d = {sumBit, sSr_q[WIDTH-1:1]};

    // A start seen in DONE reloads exactly as from IDLE, giving back-to-back operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            aSr_q   <= '0;
            bSr_q   <= '0;
            sSr_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        aSr_q   <= a;
                        bSr_q   <= b;
                        sSr_q   <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    aSr_q <= aSr_q >> 1;
                    bSr_q <= bSr_q >> 1;
                    sSr_q <= sSr_d;
                    c_q   <= carryBit;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= sSr_d;
                        cout_q  <= carryBit;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=4 against a+b arithmetic.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int         vectors;
    int         errors;
    logic [8:0] held9;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation from IDLE; with noisy set, operands and start toggle during RUN.
    task automatic test_op(input logic [7:0] opA, input logic [7:0] opB, input bit noisy);
        logic [8:0] expect9;
        expect9 = {1'b0, opA} + {1'b0, opB};
        a8 = opA;
        b8 = opB;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (noisy) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                start8 = 1'($urandom_range(0, 1));
            end
            vectors++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL run_flags cycle %0d: busy=%b done=%b, required busy=1 done=0", i, busy8, done8);
            end
            vectors++;
            if ({cout8, sum8} !== held9) begin
                errors++;
                $display("[TB] FAIL result_hold cycle %0d: got %h, required %h", i, {cout8, sum8}, held9);
            end
            tick();
        end
        start8 = 1'b0;
        vectors++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse a=%h b=%h: busy=%b done=%b, required busy=0 done=1", opA, opB, busy8, done8);
        end
        vectors++;
        if ({cout8, sum8} !== expect9) begin
            errors++;
            $display("[TB] FAIL sum a=%h b=%h: got %h, required %h", opA, opB, {cout8, sum8}, expect9);
        end
        held9 = expect9;
        tick();
        vectors++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_done: busy=%b done=%b, required both 0", busy8, done8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;
        tick();
        tick();
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_w8: busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
        end
        vectors++;
        if ({busy4, done4, cout4, sum4} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_w4: busy=%b done=%b cout=%b sum=%h, required all 0", busy4, done4, cout4, sum4);
        end
        rst = 1'b0;
        held9 = '0;
        tick();
    endtask

    task automatic test_directed();
        test_op(8'h00, 8'h00, 1'b0);
        test_op(8'hFF, 8'h01, 1'b0);
        test_op(8'hFF, 8'hFF, 1'b0);
        test_op(8'hA5, 8'h5A, 1'b1);
    endtask

    task automatic test_reset_midrun();
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_async: busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrun_reset_hold %0d: busy=%b done=%b, required both 0", i, busy8, done8);
            end
        end
        rst = 1'b0;
        held9 = '0;
        tick();
        test_op(8'h03, 8'h05, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            test_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // Exhaustive WIDTH=4 sweep with start held high; each result must land exactly 5 cycles after the last.
    task automatic test_back_to_back();
        logic [4:0] expect5;
        logic [7:0] pair;
        pair = 8'd0;
        a4 = pair[7:4];
        b4 = pair[3:0];
        start4 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            expect5 = {1'b0, a4} + {1'b0, b4};
            tick();
            pair = 8'(p + 1);
            a4 = pair[7:4];
            b4 = pair[3:0];
            for (int i = 0; i < 3; i++) begin
                tick();
                vectors++;
                if (done4 !== 1'b0 || busy4 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing pair %0d cycle %0d: busy=%b done=%b, required busy=1 done=0", p, i, busy4, done4);
                end
            end
            tick();
            vectors++;
            if (done4 !== 1'b1 || busy4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_done pair %0d: busy=%b done=%b, required busy=0 done=1", p, busy4, done4);
            end
            vectors++;
            if ({cout4, sum4} !== expect5) begin
                errors++;
                $display("[TB] FAIL b2b_sum pair %0d: got %h, required %h", p, {cout4, sum4}, expect5);
            end
        end
        start4 = 1'b0;
        tick();
        vectors++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_stop: busy=%b done=%b, required both 0", busy4, done4);
        end
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        held9 = '0;
        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;
        test_reset();
        test_directed();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that consumes the team's half-adder cell. Two half adders and an OR form a full adder, and a registered carry feeds it back one bit per clock, LSB first. It sits directly downstream of the half-adder stage and is the first sequential arithmetic block in the design. It accepts one operand pair per start pulse and returns the sum and carry-out with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result register; holds the last completed sum.
- cout  out  1  result carry-out; holds the last completed carry.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**, start=1:
  - load a_sr<=a and b_sr<=b.
  - clear the internal carry register c and the sum shift register s_sr.
  - set bit counter cnt<=0 and go to RUN.
  - start=0: stay in IDLE.
- **RUN**, every cycle:
  - the full adder computes (p, q) = FA(a_sr[0], b_sr[0], c), where p is the sum bit and q the carry.
  - a_sr and b_sr shift right with zero fill.
  - s_sr shifts right with p inserted at the MSB.
  - c<=q and cnt<=cnt+1.
  - start is ignored.
- **RUN exit**, on the cycle with cnt==WIDTH-1:
  - sum<={p, s_sr[WIDTH-1:1]} and cout<=q.
  - go to DONE.
- **DONE**: done=1 for exactly this cycle.
  - start=1 is accepted exactly as in IDLE and goes to RUN, which gives back-to-back operation.
  - start=0 goes to IDLE.
- sum and cout change only on the RUN-exit edge. During a later operation they keep the previous result.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1). There is no carry-in.
- **Reset**, any state, asserted at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - internal registers (a_sr, b_sr, s_sr, c, cnt) all cleared.
  - The operation in progress is discarded and no done is produced.
- cnt is $clog2(WIDTH) bits wide and never wraps in normal operation.

## Timing
- Start accepted at edge T0:
  - busy=1 from T0 to T0+WIDTH (busy is a decode of state==RUN).
  - result registered at edge T0+WIDTH.
  - done=1 between T0+WIDTH and T0+WIDTH+1.
- Latency: WIDTH+1 clocks from the accepting edge to the end of the done pulse.
- Throughput: one operation per WIDTH+1 clocks when start is held high.
- done and busy are never high together.
- a and b may change freely after the accepting edge.

## Structure
- Package serial_adder_pkg holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default WIDTH constant.
- Sub-module full_adder (inputs x, y, ci; outputs s, co) holds:
  - two instances of the existing half-adder cell;
  - co = carry1 | carry2.
- full_adder is instantiated once in serial_adder. The adder datapath contains no other logic.

## Test plan
- WIDTH=8, a=0x00, b=0x00, start at T0 -> busy for 8 cycles; done at T0+8; sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- a=0xA5, b=0x5A, then new start pulses and operand changes during RUN:
  - sum=0xFF, cout=0;
  - in-RUN starts ignored;
  - sum/cout hold the prior result until done.
- Reset mid-RUN (cycle 4), then start a=0x03, b=0x05:
  - outputs 0 and no done during reset;
  - the new operation gives sum=0x08, cout=0.
- WIDTH=4:
  - exhaustive 256-pair sweep with start held high (back-to-back via DONE);
  - each done has {cout,sum}==a+b;
  - done pulses spaced exactly 5 cycles apart.
